// File: rtl/peri_timer_slave.sv
// Machine-timer slave on the peripheral channel: 64-bit mtime/mtimecmp, prescaler, level IRQ; PERI_TIMER_SNAPSHOT_EN adds a tear-free MTIME_HI shadow.
// Latency: write commits one edge after accept, read data valid the cycle after accept, complete pulse one cycle after either.
// Backpressure: one transaction in flight; both READYs low outside IDLE, read data held until DATA_FROM_PERI_READY.
module peri_timer_slave #(
    parameter logic [31:0] BASE_ADDR    = 32'hE000_0000,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [31:0] RD_ADDR_TO_PERI,
    input  logic        RD_ADDR_TO_PERI_VALID,
    output logic        RD_ADDR_TO_PERI_READY,
    input  logic [31:0] WR_ADDR_TO_PERI,
    input  logic [31:0] DATA_TO_PERI,
    input  logic        WR_TO_PERI_VALID,
    output logic        WR_TO_PERI_READY,
    output logic [31:0] DATA_FROM_PERI,
    output logic        DATA_FROM_PERI_VALID,
    input  logic        DATA_FROM_PERI_READY,
    output logic        TRANSACTION_COMPLETE_PERI,
    output logic        TIMER_IRQ
);

    typedef enum logic [1:0] {IDLE, WR_EXEC, RD_DATA, CMPL} state_t;

    state_t      state, state_nxt;
    logic [31:0] wr_addr, wr_data, rd_data, rd_mux, mtime_hi_rd;
    logic [63:0] mtime, mtimecmp;
    logic [15:0] div, pcnt;
    logic        en, ie, irq;
    logic        wr_take, rd_take, wr_hit, rd_hit, tick, cmp_ge;
    logic        wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl;

    // A simultaneous read is left pending: the write is taken first.
    assign wr_take = (state == IDLE) && WR_TO_PERI_VALID;
    assign rd_take = (state == IDLE) && RD_ADDR_TO_PERI_VALID && !WR_TO_PERI_VALID;
    assign wr_hit  = (wr_addr[31:8] == BASE_ADDR[31:8]);
    assign rd_hit  = (RD_ADDR_TO_PERI[31:8] == BASE_ADDR[31:8]);

    assign wr_mlo  = (state == WR_EXEC) && wr_hit && (wr_addr[7:0] == 8'h00);
    assign wr_mhi  = (state == WR_EXEC) && wr_hit && (wr_addr[7:0] == 8'h04);
    assign wr_clo  = (state == WR_EXEC) && wr_hit && (wr_addr[7:0] == 8'h08);
    assign wr_chi  = (state == WR_EXEC) && wr_hit && (wr_addr[7:0] == 8'h0C);
    assign wr_ctrl = (state == WR_EXEC) && wr_hit && (wr_addr[7:0] == 8'h10);

    assign tick   = en && (pcnt == div);
    assign cmp_ge = (mtime >= mtimecmp);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_take) begin
                    state_nxt = WR_EXEC;
                end else if (rd_take) begin
                    state_nxt = RD_DATA;
                end
            end
            WR_EXEC: state_nxt = CMPL;
            RD_DATA: begin
                if (DATA_FROM_PERI_READY) begin
                    state_nxt = CMPL;
                end
            end
            CMPL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // READYs stay low while reset is held even though the state register already reads IDLE.
    always_comb begin
        RD_ADDR_TO_PERI_READY     = 1'b0;
        WR_TO_PERI_READY          = 1'b0;
        DATA_FROM_PERI_VALID      = 1'b0;
        TRANSACTION_COMPLETE_PERI = 1'b0;
        case (state)
            IDLE: begin
                RD_ADDR_TO_PERI_READY = RESETN;
                WR_TO_PERI_READY      = RESETN;
            end
            RD_DATA: DATA_FROM_PERI_VALID      = 1'b1;
            CMPL:    TRANSACTION_COMPLETE_PERI = 1'b1;
            default: ;
        endcase
    end

    assign DATA_FROM_PERI = rd_data;
    assign TIMER_IRQ      = irq;

`ifdef PERI_TIMER_SNAPSHOT_EN
    logic [31:0] shadow;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            shadow <= 32'h0;
        end else if (rd_take && rd_hit && (RD_ADDR_TO_PERI[7:0] == 8'h00)) begin
            shadow <= mtime[63:32];
        end
    end

    assign mtime_hi_rd = shadow;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    always_comb begin
        rd_mux = 32'h0;
        if (rd_hit) begin
            case (RD_ADDR_TO_PERI[7:0])
                8'h00:   rd_mux = mtime[31:0];
                8'h04:   rd_mux = mtime_hi_rd;
                8'h08:   rd_mux = mtimecmp[31:0];
                8'h0C:   rd_mux = mtimecmp[63:32];
                8'h10:   rd_mux = {div, 14'h0, ie, en};
                8'h14:   rd_mux = {31'h0, cmp_ge};
                default: rd_mux = 32'h0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_addr <= 32'h0;
            wr_data <= 32'h0;
            rd_data <= 32'h0;
        end else begin
            if (wr_take) begin
                wr_addr <= WR_ADDR_TO_PERI;
                wr_data <= DATA_TO_PERI;
            end
            if (rd_take) begin
                rd_data <= rd_mux;
            end
        end
    end

    // A software write to either mtime half replaces that cycle's increment.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            mtime    <= 64'h0;
            mtimecmp <= {64{1'b1}};
            pcnt     <= 16'h0;
            en       <= 1'b0;
            ie       <= 1'b0;
            div      <= PRESCALE_RST;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                pcnt <= 16'h0;
            end else if (en) begin
                pcnt <= tick ? 16'h0 : pcnt + 16'd1;
            end

            if (wr_mlo) begin
                mtime[31:0] <= wr_data;
            end else if (wr_mhi) begin
                mtime[63:32] <= wr_data;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_clo) begin
                mtimecmp[31:0] <= wr_data;
            end
            if (wr_chi) begin
                mtimecmp[63:32] <= wr_data;
            end

            if (wr_ctrl) begin
                en  <= wr_data[0];
                ie  <= wr_data[1];
                div <= wr_data[31:16];
            end

            irq <= ie && cmp_ge;
        end
    end

endmodule

// File: tb/tb_peri_timer_slave.sv
// Bench for peri_timer_slave: directed scenarios plus random register traffic against an analytic timer model.
`timescale 1ns/1ps
module tb_peri_timer_slave;

    localparam logic [31:0] BASE = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rd_addr = 32'h0, wr_addr = 32'h0, wr_dat = 32'h0;
    logic        rd_addr_vld = 1'b0, wr_vld = 1'b0, rd_dat_rdy = 1'b0;
    logic        rd_addr_rdy, wr_rdy, rd_dat_vld, cmpl, irq;
    logic [31:0] rd_dat;

    peri_timer_slave #(.BASE_ADDR(BASE), .PRESCALE_RST(16'd0)) dut (
        .CLK(clk), .RESETN(rst_n),
        .RD_ADDR_TO_PERI(rd_addr), .RD_ADDR_TO_PERI_VALID(rd_addr_vld), .RD_ADDR_TO_PERI_READY(rd_addr_rdy),
        .WR_ADDR_TO_PERI(wr_addr), .DATA_TO_PERI(wr_dat), .WR_TO_PERI_VALID(wr_vld), .WR_TO_PERI_READY(wr_rdy),
        .DATA_FROM_PERI(rd_dat), .DATA_FROM_PERI_VALID(rd_dat_vld), .DATA_FROM_PERI_READY(rd_dat_rdy),
        .TRANSACTION_COMPLETE_PERI(cmpl), .TIMER_IRQ(irq)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge when sampled at a falling edge.
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: mtime is an anchor value plus elapsed prescaled periods since the anchor edge.
    logic [63:0] m_base, m_cmp;
    longint      m_acyc;
    int          m_acnt;
    logic        m_en, m_ie;
    logic [15:0] m_div;
    logic [31:0] m_shadow;

    function automatic logic [63:0] mt_at(input longint c);
        if (!m_en) return m_base;
        return m_base + 64'((longint'(m_acnt) + c - m_acyc) / (longint'(m_div) + 1));
    endfunction

    function automatic int pc_at(input longint c);
        if (!m_en) return m_acnt;
        return int'((longint'(m_acnt) + c - m_acyc) % (longint'(m_div) + 1));
    endfunction

    function automatic logic m_irq();
        return m_ie && (mt_at(cyc - 1) >= m_cmp);
    endfunction

    task automatic m_reset(input longint c);
        m_base = 64'h0; m_cmp = {64{1'b1}}; m_acyc = c; m_acnt = 0;
        m_en = 1'b0; m_ie = 1'b0; m_div = 16'd0; m_shadow = 32'h0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a, input longint h);
        logic [63:0] mt = mt_at(h - 1);
        logic [31:0] r = 32'h0;
        if (a[31:8] == BASE[31:8]) begin
            case (a[7:0])
                8'h00: begin r = mt[31:0]; m_shadow = mt[63:32]; end
`ifdef PERI_TIMER_SNAPSHOT_EN
                8'h04: r = m_shadow;
`else
                8'h04: r = mt[63:32];
`endif
                8'h08: r = m_cmp[31:0];
                8'h0C: r = m_cmp[63:32];
                8'h10: r = {m_div, 14'h0, m_ie, m_en};
                8'h14: r = {31'h0, mt >= m_cmp};
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input longint c);
        logic [63:0] prev = mt_at(c - 1);
        int pc = pc_at(c);
        if (a[31:8] == BASE[31:8]) begin
            case (a[7:0])
                8'h00: begin m_base = {prev[63:32], d}; m_acnt = pc; m_acyc = c; end
                8'h04: begin m_base = {d, prev[31:0]}; m_acnt = pc; m_acyc = c; end
                8'h08: m_cmp[31:0] = d;
                8'h0C: m_cmp[63:32] = d;
                8'h10: begin
                    m_base = mt_at(c); m_acnt = 0; m_acyc = c;
                    m_en = d[0]; m_ie = d[1]; m_div = d[31:16];
                end
                default: ;
            endcase
        end
    endtask

    // Bus tasks are entered and left at a falling edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        longint h;
        wr_addr = a; wr_dat = d; wr_vld = 1'b1;
        while (!wr_rdy && n < 50) begin @(negedge clk); n++; end
        chk("wr_accept", 32'(wr_rdy), 1);
        h = cyc + 1;
        @(negedge clk);
        wr_vld = 1'b0;
        chk("wr_exec_cmpl", 32'(cmpl), 0);
        chk("wr_exec_rdy", 32'(wr_rdy), 0);
        @(negedge clk);
        chk("wr_cmpl", 32'(cmpl), 1);
        m_write(a, d, h + 1);
        @(negedge clk);
        chk("wr_cmpl_drop", 32'(cmpl), 0);
        chk("wr_rdy_back", 32'(wr_rdy), 1);
        chk("wr_irq", 32'(irq), 32'(m_irq()));
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] got);
        int n = 0;
        longint h;
        logic [31:0] exp;
        rd_addr = a; rd_addr_vld = 1'b1;
        while (!(rd_addr_rdy && !wr_vld) && n < 50) begin @(negedge clk); n++; end
        chk("rd_accept", 32'(rd_addr_rdy), 1);
        h = cyc + 1;
        exp = m_read(a, h);
        @(negedge clk);
        rd_addr_vld = 1'b0;
        got = rd_dat;
        chk("rd_vld", 32'(rd_dat_vld), 1);
        chk("rd_data", rd_dat, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rd_hold_vld", 32'(rd_dat_vld), 1);
            chk("rd_hold_data", rd_dat, exp);
            chk("rd_hold_cmpl", 32'(cmpl), 0);
        end
        rd_dat_rdy = 1'b1;
        @(negedge clk);
        rd_dat_rdy = 1'b0;
        chk("rd_cmpl", 32'(cmpl), 1);
        chk("rd_vld_drop", 32'(rd_dat_vld), 0);
        @(negedge clk);
        chk("rd_cmpl_drop", 32'(cmpl), 0);
        chk("rd_rdy_back", 32'(rd_addr_rdy), 1);
        chk("rd_irq", 32'(irq), 32'(m_irq()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("irq", 32'(irq), 32'(m_irq()));
        end
    endtask

    logic [7:0] offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h02};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] d, a, dat;
        int n;
        m_reset(0);
        repeat (3) @(negedge clk);
        chk("rst_rd_rdy", 32'(rd_addr_rdy), 0);
        chk("rst_wr_rdy", 32'(wr_rdy), 0);
        chk("rst_vld", 32'(rd_dat_vld), 0);
        chk("rst_cmpl", 32'(cmpl), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_data", rd_dat, 0);
        m_reset(cyc);
        rst_n = 1'b1;
        @(negedge clk);

        do_read(BASE + 32'h00, 0, d);
        do_read(BASE + 32'h08, 0, d);
        chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
        do_read(BASE + 32'h10, 0, d);

        // Counting with DIV=0, then DIV=3.
        do_write(BASE + 32'h10, 32'h0000_0001);
        idle(10);
        do_read(BASE + 32'h00, 0, d);
        do_write(BASE + 32'h10, 32'h0003_0001);
        do_read(BASE + 32'h00, 0, d);
        idle(9);
        do_read(BASE + 32'h00, 1, d);

        // Wrap from all-ones, with a long read-data stall.
        do_write(BASE + 32'h10, 32'h0);
        do_write(BASE + 32'h00, 32'hFFFF_FFFF);
        do_write(BASE + 32'h04, 32'hFFFF_FFFF);
        do_write(BASE + 32'h10, 32'h0000_0001);
        do_read(BASE + 32'h04, 0, d);
        do_read(BASE + 32'h00, 5, d);

        // Interrupt rise at mtime=0x20, then drop after moving mtimecmp up.
        do_write(BASE + 32'h10, 32'h0);
        do_write(BASE + 32'h00, 32'h0);
        do_write(BASE + 32'h04, 32'h0);
        do_write(BASE + 32'h08, 32'h20);
        do_write(BASE + 32'h0C, 32'h0);
        do_write(BASE + 32'h10, 32'h3);
        idle(40);
        do_read(BASE + 32'h14, 0, d);
        do_write(BASE + 32'h0C, 32'h1);
        idle(3);
        do_read(BASE + 32'h14, 0, d);

        // Write and read offered together: write first, read sees its data.
        rd_addr = BASE + 32'h08; rd_addr_vld = 1'b1;
        do_write(BASE + 32'h08, 32'h55);
        do_read(BASE + 32'h08, 0, d);
        chk("simul_rd", d, 32'h55);

        for (int k = 0; k < 80; k++) begin
            a = {BASE[31:8], offs[$urandom_range(0, 7)]};
            if ($urandom_range(0, 9) == 0) a = $urandom;
            if ($urandom_range(0, 9) < 4) begin
                dat = $urandom;
                if (a[7:0] == 8'h10) dat[31:16] = 16'($urandom_range(0, 3));
                do_write(a, dat);
            end else begin
                do_read(a, $urandom_range(0, 3), d);
            end
            idle($urandom_range(0, 3));
        end

        // Reset while read data is waiting for READY.
        rd_addr = BASE; rd_addr_vld = 1'b1;
        n = 0;
        while (!rd_addr_rdy && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        rd_addr_vld = 1'b0;
        chk("mid_rd_vld", 32'(rd_dat_vld), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld", 32'(rd_dat_vld), 0);
        chk("mid_rst_cmpl", 32'(cmpl), 0);
        chk("mid_rst_rd_rdy", 32'(rd_addr_rdy), 0);
        chk("mid_rst_wr_rdy", 32'(wr_rdy), 0);
        @(negedge clk);
        chk("mid_rst_cmpl2", 32'(cmpl), 0);
        m_reset(cyc);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(BASE + 32'h00, 0, d);
        do_read(BASE + 32'h04, 0, d);
        do_read(BASE + 32'h0C, 0, d);
        do_read(BASE + 32'h10, 0, d);
        chk("post_rst_irq", 32'(irq), 0);

        // Low half crosses 2^32 between the LO and HI reads.
        do_write(BASE + 32'h04, 32'h1);
        do_write(BASE + 32'h00, 32'hFFFF_FFFF);
        do_write(BASE + 32'h10, 32'h00FF_0001);
        do_read(BASE + 32'h00, 0, d);
        idle(300);
        do_read(BASE + 32'h04, 0, d);
`ifdef PERI_TIMER_SNAPSHOT_EN
        chk("snap_hi", d, 32'h1);
`else
        chk("live_hi", d, 32'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
